// File: rtl/dcache_next_level_responder_if.sv
// Request/response handshake bundle between the data cache (master) and the
// next-level responder (slave). Line addresses are add[31:6] of the access.
interface dcache_next_level_responder_if #(
   parameter int ADDR_BITS = 26
);
   logic                 req_valid;
   logic                 req_write;
   logic [ADDR_BITS-1:0] req_addr;
   logic                 req_ready;
   logic                 resp_valid;
   logic                 resp_write;
   logic [ADDR_BITS-1:0] resp_addr;
   logic                 resp_ready;

   modport master (
      output req_valid, req_write, req_addr, resp_ready,
      input  req_ready, resp_valid, resp_write, resp_addr
   );

   modport slave (
      input  req_valid, req_write, req_addr, resp_ready,
      output req_ready, resp_valid, resp_write, resp_addr
   );
endinterface

// File: rtl/dcache_next_level_responder.sv
// Next-level (L2 side) responder for data cache line requests.
// Requests are queued in an in-order FIFO and serviced one at a time after a
// fixed latency; each completion is presented on a valid/ready response.
// Optional feature: define DCACHE_REQ_COALESCE_EN to merge a request whose
// address matches the most recently queued entry into that entry.
module dcache_next_level_responder #(
   parameter int DEPTH     = 8,
   parameter int LATENCY   = 4,
   parameter int ADDR_BITS = 26
) (
   input  logic                           clk,
   input  logic                           rst,
   dcache_next_level_responder_if.slave   bus,
   output logic [31:0]                    serviced,
   output logic [31:0]                    overflows,
   output logic [$clog2(DEPTH+1)-1:0]     occupancy
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = $clog2(DEPTH);
   localparam int LW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   // Each entry is {write flag, line address}
   logic [ADDR_BITS:0]   mem [DEPTH];
   logic [PW-1:0]        wr_ptr_reg;
   logic [PW-1:0]        rd_ptr_reg;
   logic [CW-1:0]        count_reg;
   logic [CW-1:0]        count_next;
   logic [1:0]           state_reg;
   logic [LW-1:0]        lat_cnt_reg;
   logic [ADDR_BITS:0]   work_reg;
   logic                 resp_valid_reg;
   logic                 resp_write_reg;
   logic [ADDR_BITS-1:0] resp_addr_reg;
   logic [31:0]          serviced_reg;
   logic [31:0]          overflows_reg;

   logic not_full;
   logic merge_hit;
   logic accept;
   logic push;
   logic merge;
   logic pop;
   logic drop;
   logic resp_done;

   assign not_full  = (count_reg < CW'(DEPTH));
   assign pop       = (state_reg == ST_IDLE) && (count_reg != '0);
   assign resp_done = (state_reg == ST_RESP) && bus.resp_ready;

`ifdef DCACHE_REQ_COALESCE_EN
   logic [ADDR_BITS-1:0] last_addr_reg;

   // A tail entry that is being popped this very edge is already on its way to
   // the work register, so it is no longer a merge target.
   assign merge_hit = (count_reg != '0) && (bus.req_addr == last_addr_reg) &&
                      !(pop && (count_reg == CW'(1)));

   // Remember the address of the most recently queued entry
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_addr_reg <= '0;
      end else if (push) begin
         last_addr_reg <= bus.req_addr;
      end
   end
`else
   assign merge_hit = 1'b0;
`endif

   assign bus.req_ready = not_full || merge_hit;
   assign accept        = bus.req_valid && bus.req_ready;
   assign merge         = accept && merge_hit;
   assign push          = accept && !merge_hit;
   assign drop          = bus.req_valid && !bus.req_ready;

   assign count_next = count_reg + CW'(push) - CW'(pop);

   // FIFO storage: new entries at the tail; a merge only ever sets the write flag
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_reg] <= {bus.req_write, bus.req_addr};
      end else if (merge && bus.req_write) begin
         mem[wr_ptr_reg - 1'b1] <= {1'b1, bus.req_addr};
      end
   end

   // Registered read of the head entry into the work register on pop
   always_ff @(posedge clk) begin
      if (pop) begin
         work_reg <= mem[rd_ptr_reg];
      end
   end

   // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is 2^n)
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
         count_reg <= count_next;
      end
   end

   // Service FSM: pop from IDLE, count down the latency, hold the response
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg      <= ST_IDLE;
         lat_cnt_reg    <= '0;
         resp_valid_reg <= 1'b0;
         resp_write_reg <= 1'b0;
         resp_addr_reg  <= '0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (pop) begin
                  lat_cnt_reg <= LW'(LATENCY - 1);
                  state_reg   <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               if (lat_cnt_reg == '0) begin
                  resp_valid_reg <= 1'b1;
                  resp_write_reg <= work_reg[ADDR_BITS];
                  resp_addr_reg  <= work_reg[ADDR_BITS-1:0];
                  state_reg      <= ST_RESP;
               end else begin
                  lat_cnt_reg <= lat_cnt_reg - 1'b1;
               end
            end
            ST_RESP: begin
               if (bus.resp_ready) begin
                  resp_valid_reg <= 1'b0;
                  state_reg      <= ST_IDLE;
               end
            end
            default: begin
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

   // Saturating completion and drop counters
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         serviced_reg  <= '0;
         overflows_reg <= '0;
      end else begin
         if (resp_done && (serviced_reg != 32'hFFFF_FFFF)) begin
            serviced_reg <= serviced_reg + 32'd1;
         end
         if (drop && (overflows_reg != 32'hFFFF_FFFF)) begin
            overflows_reg <= overflows_reg + 32'd1;
         end
      end
   end

   assign bus.resp_valid = resp_valid_reg;
   assign bus.resp_write = resp_write_reg;
   assign bus.resp_addr  = resp_addr_reg;
   assign serviced       = serviced_reg;
   assign overflows      = overflows_reg;
   assign occupancy      = count_reg;

endmodule

// File: tb/tb_dcache_next_level_responder.sv
// Self-checking bench for dcache_next_level_responder: a vector table for
// single-request latency/data, hand-written sequences for the multi-cycle
// corners, and a scoreboard queue checked whenever a response handshakes.
module tb_dcache_next_level_responder;
   localparam int DEPTH   = 8;
   localparam int LATENCY = 4;
   localparam int AB      = 26;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [31:0]       serviced;
   logic [31:0]       overflows;
   logic [3:0]        occupancy;

   dcache_next_level_responder_if #(.ADDR_BITS(AB)) bus ();

   dcache_next_level_responder #(
      .DEPTH     (DEPTH),
      .LATENCY   (LATENCY),
      .ADDR_BITS (AB)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .serviced  (serviced),
      .overflows (overflows),
      .occupancy (occupancy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          w;
      logic [AB-1:0] a;
      int            exp_lat;
   } vec_t;

   vec_t          vecs [4];
   logic [AB:0]   sbq [$];
   int            checks       = 0;
   int            failures     = 0;
   int            resp_cnt     = 0;
   int            exp_serviced = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Hold one request for exactly one clock edge; queue its expected response
   task automatic send(input logic w, input logic [AB-1:0] a, input bit acc);
      bus.req_valid = 1'b1;
      bus.req_write = w;
      bus.req_addr  = a;
      @(posedge clk);
      if (acc) sbq.push_back({w, a});
      #1;
      bus.req_valid = 1'b0;
   endtask

   task automatic wait_resp(input int budget, output int cyc);
      cyc = 0;
      while (bus.resp_valid !== 1'b1 && cyc < budget) begin
         tick();
         cyc++;
      end
      if (bus.resp_valid !== 1'b1) begin
         checks++;
         failures++;
         $display("FAIL resp_timeout: resp_valid not seen within %0d cycles", budget);
      end
   endtask

   task automatic wait_drain(input int budget);
      int cyc;
      cyc = 0;
      while (sbq.size() != 0 && cyc < budget) begin
         tick();
         cyc++;
      end
      tick();
      tick();
      if (sbq.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL drain_timeout: %0d responses still outstanding", sbq.size());
      end
   endtask

   // Scoreboard: every response handshake must match the oldest expectation
   always @(negedge clk) begin : mon
      logic [AB:0] e;
      if (!rst && bus.resp_valid && bus.resp_ready) begin
         resp_cnt++;
         checks++;
         if (sbq.size() == 0) begin
            failures++;
            $display("FAIL unexpected_resp: got addr %0h write %0b, none expected",
                     bus.resp_addr, bus.resp_write);
         end else begin
            e = sbq.pop_front();
            $display("resp %0d: addr=%0h write=%0b", resp_cnt, bus.resp_addr, bus.resp_write);
            if ({bus.resp_write, bus.resp_addr} !== e) begin
               failures++;
               $display("FAIL resp_data: got write %0b addr %0h expected write %0b addr %0h",
                        bus.resp_write, bus.resp_addr, e[AB], e[AB-1:0]);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      int r0;
      int n_exp;
      bus.req_valid  = 1'b0;
      bus.req_write  = 1'b0;
      bus.req_addr   = '0;
      bus.resp_ready = 1'b0;

      vecs[0] = '{1'b0, 26'h0ABCDEF, LATENCY + 1};
      vecs[1] = '{1'b1, 26'h3FFFFFF, LATENCY + 1};
      vecs[2] = '{1'b0, 26'h0000000, LATENCY + 1};
      vecs[3] = '{1'b1, 26'h1555555, LATENCY + 1};

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_resp_valid", bus.resp_valid, 0);
      check("rst_req_ready", bus.req_ready, 1);
      check("rst_occupancy", occupancy, 0);
      check("rst_serviced", serviced, 0);
      check("rst_overflows", overflows, 0);
      check("rst_resp_addr", bus.resp_addr, 0);
      rst = 1'b0;
      tick();

      // Single requests: latency, data, serviced count
      bus.resp_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         send(vecs[i].w, vecs[i].a, 1'b1);
         wait_resp(20, cyc);
         check("t1_latency", cyc, vecs[i].exp_lat);
         check("t1_addr", bus.resp_addr, vecs[i].a);
         check("t1_write", bus.resp_write, vecs[i].w);
         tick();
         exp_serviced++;
         check("t1_serviced", serviced, exp_serviced);
         check("t1_valid_low", bus.resp_valid, 0);
         tick();
      end

      // Fill past capacity while responses are stalled
      bus.resp_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         send(logic'(i[0]), AB'(32'h100 + i), i < 9);
      end
      check("t2_occupancy", occupancy, DEPTH);
      check("t2_req_ready", bus.req_ready, 0);
      check("t2_overflows", overflows, 1);
      bus.resp_ready = 1'b1;
      r0 = resp_cnt;
      wait_drain(200);
      check("t2_resp_count", resp_cnt - r0, 9);
      exp_serviced += 9;
      check("t2_serviced", serviced, exp_serviced);
      check("t2_occupancy_empty", occupancy, 0);

      // Long response stall must keep outputs stable
      bus.resp_ready = 1'b0;
      send(1'b1, 26'h2A5A5A5, 1'b1);
      wait_resp(20, cyc);
      for (int i = 0; i < 20; i++) begin
         check("t3_hold", {bus.resp_valid, bus.resp_write, bus.resp_addr},
               {1'b1, 1'b1, 26'h2A5A5A5});
         tick();
      end
      bus.resp_ready = 1'b1;
      tick();
      exp_serviced++;
      check("t3_serviced", serviced, exp_serviced);
      check("t3_valid_low", bus.resp_valid, 0);

      // Asynchronous reset while BUSY discards the in-flight request
      send(1'b0, 26'h1234567, 1'b1);
      tick();
      tick();
      rst = 1'b1;
      #1;
      sbq.delete();
      exp_serviced = 0;
      check("t4_resp_valid", bus.resp_valid, 0);
      check("t4_req_ready", bus.req_ready, 1);
      check("t4_occupancy", occupancy, 0);
      check("t4_serviced", serviced, 0);
      check("t4_overflows", overflows, 0);
      check("t4_resp_addr", bus.resp_addr, 0);
      check("t4_resp_write", bus.resp_write, 0);
      tick();
      rst = 1'b0;
      r0 = resp_cnt;
      repeat (15) tick();
      check("t4_no_resp", resp_cnt - r0, 0);
      check("t4_valid_stays_low", bus.resp_valid, 0);

      // Same address twice while the FIFO is stalled
      bus.resp_ready = 1'b0;
      send(1'b0, 26'h0000007, 1'b1);
      wait_resp(20, cyc);
`ifdef DCACHE_REQ_COALESCE_EN
      send(1'b0, 26'h0000040, 1'b0);
      send(1'b1, 26'h0000040, 1'b0);
      sbq.push_back({1'b1, 26'h0000040});
      check("t5_occupancy", occupancy, 1);
      n_exp = 2;
`else
      send(1'b0, 26'h0000040, 1'b1);
      send(1'b1, 26'h0000040, 1'b1);
      check("t5_occupancy", occupancy, 2);
      n_exp = 3;
`endif
      bus.resp_ready = 1'b1;
      r0 = resp_cnt;
      wait_drain(200);
      check("t5_resp_count", resp_cnt - r0, n_exp);
      exp_serviced += n_exp;
      check("t5_serviced", serviced, exp_serviced);
      check("t5_overflows", overflows, 0);

      // Twenty sequential addresses across pointer wrap
      r0 = resp_cnt;
      for (int i = 0; i < 20; i++) begin
         send(1'b0, AB'(i), 1'b1);
         repeat (4) tick();
      end
      wait_drain(300);
      check("t6_resp_count", resp_cnt - r0, 20);
      exp_serviced += 20;
      check("t6_serviced", serviced, exp_serviced);
      check("t6_overflows", overflows, 0);
      check("t6_occupancy", occupancy, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
